// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD types, limits and the load-value clamp helper.
// Used by bcd_digit_cell and bcd_updown_counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Non-decimal nibbles (A..F) saturate to 9 so the counter never holds
  // an illegal BCD digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD decade with clear / optional load / up-down step.
// Optional feature macro: BCD_CNT_LOAD_EN (adds load and d ports).
// Ports:
//   clk, reset_n  clock, async active-low reset
//   step          advance this digit one place this edge
//   up            1 = increment, 0 = decrement
//   clear         sync clear to 0 (highest priority)
//   load, d       sync load of clamped d (macro only)
//   q             digit value
//   at_max/at_min q == 9 / q == 0, feed the carry/borrow chain
import bcd_pkg::*;

module bcd_digit_cell (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       up,
  input  logic       clear,
`ifdef BCD_CNT_LOAD_EN
  input  logic       load,
  input  bcd_digit_t d,
`endif
  output bcd_digit_t q,
  output logic       at_max,
  output logic       at_min
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= BCD_MIN;
    else if (clear)
      q <= BCD_MIN;
`ifdef BCD_CNT_LOAD_EN
    else if (load)
      q <= bcd_clamp(d);
`endif
    else if (step) begin
      if (up) q <= (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
      else    q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign at_max = (q == BCD_MAX);
  assign at_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-decade BCD up/down counter, wrap or saturate.
// Optional feature macro: BCD_CNT_LOAD_EN (adds load / load_val ports).
// Parameters: DIGITS (1..8), WRAP (1 wrap, 0 saturate at terminal).
// Ports:
//   clk, reset_n  clock, async active-low reset
//   enable        count-step qualifier
//   up            1 = increment, 0 = decrement
//   clear         sync clear (beats load and step)
//   load,load_val sync parallel load, digits > 9 clamp to 9 (macro only)
//   count         BCD value, digit 0 in [3:0]
//   done          combinational: enable & count at terminal for current up
import bcd_pkg::*;

module bcd_updown_counter #(
  parameter int DIGITS = 3,
  parameter int WRAP   = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                up,
  input  logic                clear,
`ifdef BCD_CNT_LOAD_EN
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`endif
  output logic [4*DIGITS-1:0] count,
  output logic                done
);

  logic [DIGITS-1:0][3:0] q;
  logic [DIGITS-1:0]      at_max, at_min, step;
  // run[k]: digits 0..k-1 all sit at the terminal digit for this direction.
  logic [DIGITS:0]        run;
  logic                   term, base_step;

  assign run[0] = 1'b1;

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      assign run[k+1] = run[k] & (up ? at_max[k] : at_min[k]);
      assign step[k]  = base_step & run[k];

      bcd_digit_cell u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .step    (step[k]),
        .up      (up),
        .clear   (clear),
`ifdef BCD_CNT_LOAD_EN
        .load    (load),
        .d       (load_val[4*k +: 4]),
`endif
        .q       (q[k]),
        .at_max  (at_max[k]),
        .at_min  (at_min[k])
      );
    end
  endgenerate

  assign term = run[DIGITS];

  // In saturate mode the step is suppressed at terminal so every digit holds.
  // clear/load priority is resolved inside the cell, so step needs no gating.
  assign base_step = enable & ((WRAP != 0) | ~term);

  assign done  = enable & term;
  assign count = q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance: DIGITS=3, WRAP=1
  logic        en, up, clr;
  logic [11:0] cnt;
  logic        dn;
  // saturating instance: DIGITS=3, WRAP=0
  logic        s_en, s_up, s_clr;
  logic [11:0] s_cnt;
  logic        s_dn;
  // cascade pair
  logic        c_en, c_clr;
  logic [11:0] c_lo, c_hi;
  logic        c_dn_lo, c_dn_hi;
`ifdef BCD_CNT_LOAD_EN
  logic        ld, s_ld;
  logic [11:0] ld_val, s_ld_val;
`endif

  bcd_updown_counter #(.DIGITS(3), .WRAP(1)) dut (
    .clk(clk), .reset_n(reset_n), .enable(en), .up(up), .clear(clr),
`ifdef BCD_CNT_LOAD_EN
    .load(ld), .load_val(ld_val),
`endif
    .count(cnt), .done(dn));

  bcd_updown_counter #(.DIGITS(3), .WRAP(0)) dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(s_en), .up(s_up), .clear(s_clr),
`ifdef BCD_CNT_LOAD_EN
    .load(s_ld), .load_val(s_ld_val),
`endif
    .count(s_cnt), .done(s_dn));

  bcd_updown_counter #(.DIGITS(3), .WRAP(1)) dut_lo (
    .clk(clk), .reset_n(reset_n), .enable(c_en), .up(1'b1), .clear(c_clr),
`ifdef BCD_CNT_LOAD_EN
    .load(1'b0), .load_val(12'h000),
`endif
    .count(c_lo), .done(c_dn_lo));

  bcd_updown_counter #(.DIGITS(3), .WRAP(1)) dut_hi (
    .clk(clk), .reset_n(reset_n), .enable(c_dn_lo), .up(1'b1), .clear(c_clr),
`ifdef BCD_CNT_LOAD_EN
    .load(1'b0), .load_val(12'h000),
`endif
    .count(c_hi), .done(c_dn_hi));

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en = 0; up = 1; clr = 0;
    s_en = 0; s_up = 1; s_clr = 0;
    c_en = 0; c_clr = 0;
`ifdef BCD_CNT_LOAD_EN
    ld = 0; ld_val = '0; s_ld = 0; s_ld_val = '0;
`endif
    #12;
    checks++; if (cnt !== 12'h000) begin errors++; $display("FAIL reset_count got %h exp 000", cnt); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", dn); end
    checks++; if (s_cnt !== 12'h000 || {c_hi, c_lo} !== 24'h0) begin errors++; $display("FAIL reset_others got %h %h%h exp 0", s_cnt, c_hi, c_lo); end
    en = 1; up = 0; #1;
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL reset_done_down got %b exp 1", dn); end
    en = 0; up = 1;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_count();
    int pulses = 0;
    en = 1; up = 1;
    for (int i = 0; i < 1000; i++) begin
      if (dn) pulses++;
      if (i == 10) begin
        checks++; if (cnt !== 12'h010) begin errors++; $display("FAIL up_10 got %h exp 010", cnt); end
      end
      if (i == 999) begin
        checks++; if (cnt !== 12'h999 || dn !== 1'b1) begin errors++; $display("FAIL up_999 got %h/%b exp 999/1", cnt, dn); end
      end
      @(negedge clk);
    end
    checks++; if (cnt !== 12'h000) begin errors++; $display("FAIL up_wrap got %h exp 000", cnt); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL up_done_pulses got %0d exp 1", pulses); end
  endtask

  task automatic test_down_wrap();
    up = 0; #1;
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL down_done got %b exp 1", dn); end
    @(negedge clk);
    checks++; if (cnt !== 12'h999 || dn !== 1'b0) begin errors++; $display("FAIL down_wrap got %h/%b exp 999/0", cnt, dn); end
    steps(10);
    checks++; if (cnt !== 12'h989) begin errors++; $display("FAIL down_10 got %h exp 989", cnt); end
    en = 0; steps(3);
    checks++; if (cnt !== 12'h989 || dn !== 1'b0) begin errors++; $display("FAIL hold got %h/%b exp 989/0", cnt, dn); end
    up = 1; en = 1; @(negedge clk);
    checks++; if (cnt !== 12'h990) begin errors++; $display("FAIL dir_change got %h exp 990", cnt); end
  endtask

  task automatic test_clear();
    clr = 1; en = 1; @(negedge clk);
    checks++; if (cnt !== 12'h000) begin errors++; $display("FAIL clear got %h exp 000", cnt); end
    up = 0; #1;
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL done_not_gated got %b exp 1", dn); end
    @(negedge clk);
    checks++; if (cnt !== 12'h000) begin errors++; $display("FAIL clear_beats_step got %h exp 000", cnt); end
    clr = 0; en = 0; up = 1;
  endtask

`ifdef BCD_CNT_LOAD_EN
  task automatic test_load();
    en = 1; ld = 1; ld_val = 12'h123; @(negedge clk);
    checks++; if (cnt !== 12'h123) begin errors++; $display("FAIL load_no_step got %h exp 123", cnt); end
    clr = 1; @(negedge clk);
    checks++; if (cnt !== 12'h000) begin errors++; $display("FAIL clear_beats_load got %h exp 000", cnt); end
    clr = 0; ld_val = 12'hA5F; @(negedge clk);
    checks++; if (cnt !== 12'h959) begin errors++; $display("FAIL load_clamp got %h exp 959", cnt); end
    ld = 0; en = 0; clr = 1; @(negedge clk); clr = 0;
  endtask
`endif

  task automatic test_saturate();
    s_up = 1; s_en = 1;
    steps(998);
    checks++; if (s_cnt !== 12'h998 || s_dn !== 1'b0) begin errors++; $display("FAIL sat_998 got %h/%b exp 998/0", s_cnt, s_dn); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_cnt !== 12'h999 || s_dn !== 1'b1) begin errors++; $display("FAIL sat_hold%0d got %h/%b exp 999/1", i, s_cnt, s_dn); end
      @(negedge clk);
    end
    s_up = 0; #1;
    checks++; if (s_dn !== 1'b0) begin errors++; $display("FAIL sat_dir_done got %b exp 0", s_dn); end
    @(negedge clk);
    checks++; if (s_cnt !== 12'h998) begin errors++; $display("FAIL sat_down got %h exp 998", s_cnt); end
    s_clr = 1; @(negedge clk); s_clr = 0;
    #1;
    checks++; if (s_dn !== 1'b1) begin errors++; $display("FAIL sat_min_done got %b exp 1", s_dn); end
    @(negedge clk);
    checks++; if (s_cnt !== 12'h000) begin errors++; $display("FAIL sat_min_hold got %h exp 000", s_cnt); end
    s_en = 0;
  endtask

  task automatic test_async_reset();
    clr = 1; @(negedge clk); clr = 0;
    en = 1; up = 1;
    steps(457);
    checks++; if (cnt !== 12'h457) begin errors++; $display("FAIL pre_reset got %h exp 457", cnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (cnt !== 12'h000) begin errors++; $display("FAIL async_reset got %h exp 000", cnt); end
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (cnt !== 12'h001) begin errors++; $display("FAIL resume got %h exp 001", cnt); end
    en = 0;
  endtask

  task automatic test_cascade();
    c_clr = 1; @(negedge clk); c_clr = 0;
    c_en = 1;
    steps(999);
    checks++; if ({c_hi, c_lo} !== 24'h000999 || c_dn_lo !== 1'b1) begin errors++; $display("FAIL cascade_pre got %h%h/%b exp 000999/1", c_hi, c_lo, c_dn_lo); end
    @(negedge clk);
    checks++; if ({c_hi, c_lo} !== 24'h001000) begin errors++; $display("FAIL cascade_carry got %h%h exp 001000", c_hi, c_lo); end
    @(negedge clk);
    checks++; if ({c_hi, c_lo} !== 24'h001001) begin errors++; $display("FAIL cascade_next got %h%h exp 001001", c_hi, c_lo); end
    c_en = 0;
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_clear();
`ifdef BCD_CNT_LOAD_EN
    test_load();
`endif
    test_saturate();
    test_async_reset();
    test_cascade();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

- Parametrised N-digit BCD counter: counts up or down, wraps or saturates, supports synchronous clear and optional parallel load.
- Successor to the fixed three-decade up-counter; it builds the count from a chain of per-digit cells with carry/borrow ripple.
- Drives display and timer logic: `count` feeds seven-segment decoders directly, and `done` chains to further counters or to timeout logic.

## Interface
Parameters:
- `DIGITS`, 3 — number of BCD decades (1..8).
- `WRAP`, 1 — 1: wrap at the terminal value; 0: saturate at the terminal value.

Ports:
- `clk`  in  1 — rising-edge clock.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `enable`  in  1 — count-step qualifier.
- `up`  in  1 — 1 = increment, 0 = decrement.
- `clear`  in  1 — synchronous clear to zero.
- `load`  in  1 — synchronous parallel load (only when `BCD_CNT_LOAD_EN` is defined).
- `load_val`  in  4*DIGITS — BCD load value, digit 0 in bits [3:0] (only when `BCD_CNT_LOAD_EN` is defined).
- `count`  out  4*DIGITS — current BCD value, digit 0 = ones in bits [3:0].
- `done`  out  1 — terminal-count indication (combinational).

## Operation
- Reset: `count` = all zeros; `done` follows from the combinational rule below (0 unless `enable`=1 and `up`=0).
- Priority per rising edge: `clear` > `load` > `enable` step > hold.
- Up step:
  - Digit 0 increments.
  - Digit k steps only when `enable` is high and digits 0..k-1 all equal 9.
  - A digit at 9 that steps becomes 0.
- Down step:
  - Digit 0 decrements.
  - Digit k steps only when `enable` is high and digits 0..k-1 all equal 0.
  - A digit at 0 that steps becomes 9.
- Terminal value: all digits 9 when `up`=1; all digits 0 when `up`=0.
- `done` = `enable` & (`count` == terminal value for the current `up`).
- `WRAP`=1, at terminal:
  - up: 9..9 → 0..0.
  - down: 0..0 → 9..9.
- `WRAP`=0, at terminal: `count` holds; `done` stays high while `enable` is held.
- Direction change takes effect on the next edge, with no extra state. `up` toggling while at terminal re-evaluates `done` combinationally.
- `load_val` digits greater than 9 are clamped to 9 on load.
- `clear` or `load` asserted with `enable` high: no step occurs that cycle.
- `done` is not gated by `clear` or `load` (it depends only on `enable`, `up`, `count`).

## Timing
- `count` is registered: it changes one edge after the qualifying inputs are sampled.
- `done` is purely combinational from `enable`, `up` and `count`, with zero cycles of latency. It is high in exactly the cycle whose edge performs the wrap (or the held step when saturating).
- Cascade rule: a downstream counter's `enable` = upstream `done`, with the same clock. This preserves single-clock carry.
- `reset_n` assertion mid-count forces `count` to zero immediately, independent of `clk`.
- Deassertion of `reset_n` is synchronised externally; the block needs no reset-release behaviour of its own.
- The carry/borrow chain is combinational across DIGITS cells. DIGITS ≤ 8 must meet timing at the target clock without pipelining.

## Configuration
- Macro: `BCD_CNT_LOAD_EN`.
- Defined:
  - `load` and `load_val` ports exist.
  - Load priority sits between clear and step, as in Operation.
  - Digit clamp applies.
- Undefined:
  - Both ports are absent.
  - The load path and clamp logic are not synthesised.
  - Priority is `clear` > `enable` step > hold.

## Structure
- Package `bcd_pkg`:
  - `bcd_digit_t` (logic [3:0]).
  - `BCD_MAX` = 4'd9.
  - `BCD_MIN` = 4'd0.
  - Function `bcd_clamp` (returns 9 for inputs above 9).
- Sub-module `bcd_digit_cell`, one per decade via generate:
  - Inputs: `clk`, `reset_n`, `step`, `up`, `clear`, `load`, `d`.
  - Outputs: `q`, `at_max`, `at_min`.
- Top level: ANDs the `at_max`/`at_min` chain to form each cell's `step`, and forms `done`.

## Test plan
- Reset, then up-count: reset_n=0, then enable=1, up=1 for 1000 cycles (DIGITS=3, WRAP=1) → `count` reaches 999, then 000. `done` is high exactly in the 999 cycle, once.
- Down-count wrap: from 000 with up=0, enable=1 → `done`=1 immediately; next `count` = 999; after 10 more steps `count` = 989.
- Saturate: WRAP=0, load 998, up=1 → 999, then holds 999 for 5 cycles with `done`=1 throughout.
- Priority and clamp (with `BCD_CNT_LOAD_EN`):
  - clear=1, load=1, enable=1 at `count` 123 → 000.
  - load=1 with load_val=12'hA5F → 959.
- Mid-operation reset: reset_n pulsed low between edges while counting at 457 → `count` goes to 000 asynchronously; counting resumes from 000 after release.
- Cascade: two instances with the second's enable tied to the first's `done` → combined 6-digit value 000999 steps to 001000 on the same edge.
